// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous framebuffer RAM between a
// high-priority streaming video reader and a CPU read/write requester.
// Video normally wins every slot it asks for; a saturating wait counter lets a
// pending CPU request preempt video once it has waited MAXWAIT cycles.
// Every RAM access takes two cycles from grant to result: the RAM address is
// registered at the grant edge, the RAM samples it on the following edge, and
// its read data is returned to the winner in the cycle after that.
module vram_arbiter #(
    parameter int A       = 10,
    parameter int D       = 8,
    parameter int MAXWAIT = 16
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         vid_req,
    input  logic [A-1:0] vid_addr,
    output logic         vid_gnt,
    output logic [D-1:0] vid_data,
    output logic         vid_valid,

    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [A-1:0] cpu_addr,
    input  logic [D-1:0] cpu_din,
    output logic [D-1:0] cpu_dout,
    output logic         cpu_ack,

    output logic [A-1:0] ram_addr,
    output logic [D-1:0] ram_din,
    output logic         ram_we,
    input  logic [D-1:0] ram_dout
);

    // CPU transaction tracker: one operation in flight at most.
    typedef enum logic [1:0] {
        C_IDLE,
        C_ISSUED,
        C_DONE
    } cpu_state_t;

    localparam logic [7:0] MAXW = 8'(MAXWAIT);

    cpu_state_t   cpu_state;
    cpu_state_t   cpu_state_nxt;

    logic [7:0]   wait_cnt;
    logic [7:0]   wait_cnt_nxt;

    logic         cpu_elig;
    logic         cpu_force;
    logic         cpu_gnt;
    logic         vid_issue;

    // Tag pipeline: stage 1 marks the cycle the RAM samples the address,
    // stage 2 marks the cycle its read data is on ram_dout.
    logic         tag1_vid;
    logic         tag1_cpu;
    logic         tag1_rd;
    logic         tag2_vid;
    logic         tag2_cpu;
    logic         tag2_rd;

    logic [D-1:0] cpu_dout_q;

    // Slot decision: who owns the RAM in this cycle.
    always_comb begin
        cpu_elig  = cpu_req && (cpu_state == C_IDLE) && !tag2_cpu;
        cpu_force = cpu_elig && (wait_cnt == MAXW);
        cpu_gnt   = cpu_force || (cpu_elig && !vid_req);
        vid_issue = vid_req && !cpu_force;
        vid_gnt   = vid_issue;
    end

    // CPU tracker next state: a granted op walks through ISSUED and DONE so a
    // request still held by the CPU cannot be granted a second time.
    always_comb begin
        cpu_state_nxt = cpu_state;
        case (cpu_state)
            C_IDLE:   if (cpu_gnt) cpu_state_nxt = C_ISSUED;
            C_ISSUED: cpu_state_nxt = C_DONE;
            C_DONE:   cpu_state_nxt = C_IDLE;
            default:  cpu_state_nxt = C_IDLE;
        endcase
    end

    // CPU tracker state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_state <= C_IDLE;
        end else begin
            cpu_state <= cpu_state_nxt;
        end
    end

    // Starvation counter: counts cycles an eligible CPU request loses the slot.
    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (!cpu_req || cpu_gnt) begin
            wait_cnt_nxt = 8'd0;
        end else if (cpu_elig && (wait_cnt < MAXW)) begin
            wait_cnt_nxt = wait_cnt + 8'd1;
        end
    end

    // Starvation counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 8'd0;
        end else begin
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // RAM issue register: only the slot winner drives the RAM; an idle slot
    // keeps the last address and data but never writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            ram_addr <= '0;
            ram_din  <= '0;
            ram_we   <= 1'b0;
        end else if (cpu_gnt) begin
            ram_addr <= cpu_addr;
            ram_din  <= cpu_din;
            ram_we   <= cpu_we;
        end else if (vid_issue) begin
            ram_addr <= vid_addr;
            ram_din  <= '0;
            ram_we   <= 1'b0;
        end else begin
            ram_we   <= 1'b0;
        end
    end

    // Tag pipeline: follows each issued access until its data comes back.
    always_ff @(posedge clk) begin
        if (reset) begin
            tag1_vid <= 1'b0;
            tag1_cpu <= 1'b0;
            tag1_rd  <= 1'b0;
            tag2_vid <= 1'b0;
            tag2_cpu <= 1'b0;
            tag2_rd  <= 1'b0;
        end else begin
            tag1_vid <= vid_issue && !cpu_gnt;
            tag1_cpu <= cpu_gnt;
            tag1_rd  <= cpu_gnt && !cpu_we;
            tag2_vid <= tag1_vid;
            tag2_cpu <= tag1_cpu;
            tag2_rd  <= tag1_rd;
        end
    end

    // Captured CPU read data, so cpu_dout keeps the last read across writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            cpu_dout_q <= '0;
        end else if (tag2_cpu && tag2_rd) begin
            cpu_dout_q <= ram_dout;
        end
    end

    // Result delivery: the owner of the returning slot sees ram_dout directly
    // in its valid/ack cycle; everything else is quiet or held.
    always_comb begin
        vid_valid = tag2_vid;
        vid_data  = tag2_vid ? ram_dout : '0;
        cpu_ack   = tag2_cpu;
        cpu_dout  = (tag2_cpu && tag2_rd) ? ram_dout : cpu_dout_q;
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: scoreboard-based bench for vram_arbiter with a behavioural
// framebuffer RAM preloaded with mem[i] = i + 0x10.
module tb_vram_arbiter;

    localparam int A       = 10;
    localparam int D       = 8;
    localparam int MAXWAIT = 4;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         vid_req = 1'b0;
    logic [A-1:0] vid_addr = '0;
    logic         vid_gnt;
    logic [D-1:0] vid_data;
    logic         vid_valid;
    logic         cpu_req = 1'b0;
    logic         cpu_we = 1'b0;
    logic [A-1:0] cpu_addr = '0;
    logic [D-1:0] cpu_din = '0;
    logic [D-1:0] cpu_dout;
    logic         cpu_ack;
    logic [A-1:0] ram_addr;
    logic [D-1:0] ram_din;
    logic         ram_we;
    logic [D-1:0] ram_dout;

    int nTests = 0;
    int nFail  = 0;
    int cyc    = 0;
    int weCount = 0;
    logic vidEnable = 1'b0;
    logic prevVid = 1'b0;
    logic loaded = 1'b0;

    logic [D-1:0] mem [0:(1<<A)-1];

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    exp_t vidQ[$];
    exp_t cpuQ[$];

    typedef struct {
        logic       we;
        logic [9:0] addr;
        logic [7:0] din;
        logic       vidOn;
        int         expDelay;
        logic [7:0] expDout;
    } vec_t;

    vec_t vecs[8];

    always #5 clk = ~clk;

    vram_arbiter #(.A(A), .D(D), .MAXWAIT(MAXWAIT)) dut (
        .clk      (clk),
        .reset    (reset),
        .vid_req  (vid_req),
        .vid_addr (vid_addr),
        .vid_gnt  (vid_gnt),
        .vid_data (vid_data),
        .vid_valid(vid_valid),
        .cpu_req  (cpu_req),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .cpu_ack  (cpu_ack),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_we   (ram_we),
        .ram_dout (ram_dout)
    );

    // Behavioural single-port RAM: preload once, then 1-cycle registered read
    // with read-during-write returning the old contents.
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < (1 << A); i++) mem[i] <= 8'(i + 16);
            loaded <= 1'b1;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_din;
            ram_dout <= mem[ram_addr];
        end
    end

    // Cycle counter, stable at the sampling (negative) edge.
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] vidExp(input logic [A-1:0] a);
        return 8'(int'(a) + 16);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Video requester: streams consecutive addresses, advancing only after a grant.
    always @(posedge clk) begin
        #2;
        if (vidEnable) begin
            if (!vid_req) vid_addr = '0;
            else if (prevVid) vid_addr = vid_addr + 1'b1;
            vid_req = 1'b1;
        end else begin
            vid_req = 1'b0;
        end
    end

    // Scoreboard monitor: compares returning video/CPU results against the
    // queues, pushes new video expectations on each grant, flushes on reset.
    always @(negedge clk) begin
        exp_t e;
        if (vid_valid) begin
            if (vidQ.size() == 0) begin
                checkOutput("vid_valid unexpected", 32'(vid_valid), 32'd0);
            end else begin
                e = vidQ.pop_front();
                checkOutput("vid_valid cycle", 32'(cyc), 32'(e.due));
                checkOutput("vid_data", 32'(vid_data), 32'(e.data));
            end
        end else if (vidQ.size() > 0 && vidQ[0].due <= cyc) begin
            e = vidQ.pop_front();
            checkOutput("vid_valid missing", 32'(vid_valid), 32'd1);
        end
        if (cpu_ack) begin
            if (cpuQ.size() == 0) begin
                checkOutput("cpu_ack unexpected", 32'(cpu_ack), 32'd0);
            end else begin
                e = cpuQ.pop_front();
                checkOutput("cpu_ack cycle", 32'(cyc), 32'(e.due));
                checkOutput("cpu_dout", 32'(cpu_dout), 32'(e.data));
            end
        end else if (cpuQ.size() > 0 && cpuQ[0].due <= cyc) begin
            e = cpuQ.pop_front();
            checkOutput("cpu_ack missing", 32'(cpu_ack), 32'd1);
        end
        if (ram_we) begin
            weCount++;
            checkOutput("ram_we on video slot", 32'(prevVid), 32'd0);
        end
        if (reset) begin
            vidQ.delete();
            cpuQ.delete();
            prevVid = 1'b0;
        end else begin
            if (vid_req && vid_gnt) vidQ.push_back('{due: cyc + 2, data: vidExp(vid_addr)});
            prevVid = vid_req && vid_gnt;
        end
    end

    task automatic pushCpu(input int due, input logic [7:0] data);
        cpuQ.push_back('{due: due, data: data});
    endtask

    // One CPU operation: raise the request, expect grant after expDelay cycles
    // and ack two cycles later, hold until ack, then release.
    task automatic applyStimulus(input logic we, input logic [9:0] addr, input logic [7:0] din,
                                 input int expDelay, input logic [7:0] expDout);
        bit seen = 1'b0;
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_din  = din;
        pushCpu(cyc + expDelay + 2, expDout);
        for (int k = 0; k < 40 && !seen; k++) begin
            @(negedge clk);
            if (cpu_ack) seen = 1'b1;
        end
        if (!seen) begin
            nTests++;
            nFail++;
            $display("[TB] FAIL cpu_ack timeout: got none, expected one for addr 0x%0h", addr);
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int c0;
        int w0;
        bit found;

        vecs[0] = '{we: 1'b1, addr: 10'h155, din: 8'hA5, vidOn: 1'b0, expDelay: 0, expDout: 8'h00};
        vecs[1] = '{we: 1'b0, addr: 10'h155, din: 8'h00, vidOn: 1'b0, expDelay: 0, expDout: 8'hA5};
        vecs[2] = '{we: 1'b1, addr: 10'h2AA, din: 8'h3C, vidOn: 1'b1, expDelay: 4, expDout: 8'hA5};
        vecs[3] = '{we: 1'b0, addr: 10'h2AA, din: 8'h00, vidOn: 1'b1, expDelay: 4, expDout: 8'h3C};
        vecs[4] = '{we: 1'b0, addr: 10'h155, din: 8'h00, vidOn: 1'b1, expDelay: 4, expDout: 8'hA5};
        vecs[5] = '{we: 1'b1, addr: 10'h3FF, din: 8'hFF, vidOn: 1'b0, expDelay: 0, expDout: 8'hA5};
        vecs[6] = '{we: 1'b0, addr: 10'h3FF, din: 8'h00, vidOn: 1'b0, expDelay: 0, expDout: 8'hFF};
        vecs[7] = '{we: 1'b0, addr: 10'h000, din: 8'h00, vidOn: 1'b0, expDelay: 0, expDout: 8'h10};

        // Power-up reset: every output quiet.
        repeat (3) @(negedge clk);
        checkOutput("reset ram_we", 32'(ram_we), 32'd0);
        checkOutput("reset ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("reset cpu_ack", 32'(cpu_ack), 32'd0);
        checkOutput("reset vid_valid", 32'(vid_valid), 32'd0);
        checkOutput("reset cpu_dout", 32'(cpu_dout), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        idleCycles(2);

        // Table of CPU operations, with and without a competing video stream.
        for (int v = 0; v < 8; v++) begin
            if (vecs[v].vidOn != vidEnable) begin
                vidEnable = vecs[v].vidOn;
                idleCycles(4);
            end
            w0 = weCount;
            applyStimulus(vecs[v].we, vecs[v].addr, vecs[v].din, vecs[v].expDelay, vecs[v].expDout);
            checkOutput($sformatf("ram_we pulses vec%0d", v), 32'(weCount - w0), 32'(vecs[v].we ? 1 : 0));
        end
        vidEnable = 1'b0;
        idleCycles(4);

        // Continuous video stream with the CPU idle.
        vidEnable = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 6 && !found; k++) begin
            @(negedge clk);
            if (vid_req) found = 1'b1;
        end
        checkOutput("vid_req start", 32'(found), 32'd1);
        for (int i = 0; i < 18; i++) begin
            if (i > 0) @(negedge clk);
            checkOutput("vid_gnt stream", 32'(vid_gnt), 32'd1);
            if (i >= 2) checkOutput("vid_valid stream", 32'(vid_valid), 32'd1);
            if (i == 2) checkOutput("vid_data first", 32'(vid_data), 32'h10);
            if (i == 3) checkOutput("vid_data second", 32'(vid_data), 32'h11);
        end

        // Starvation guard: video held, CPU read forced in on the 5th waiting cycle.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h2AA; cpu_din = 8'h00;
        c0 = cyc;
        pushCpu(c0 + 6, 8'h3C);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            checkOutput($sformatf("guard vid_gnt +%0d", i), 32'(vid_gnt), 32'(i != 4));
            if (i == 6) begin
                checkOutput("guard vid_valid gap", 32'(vid_valid), 32'd0);
                checkOutput("guard cpu_ack", 32'(cpu_ack), 32'd1);
            end
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;

        // Simultaneous requests: video wins until it drops, then CPU the same cycle.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h3FF;
        c0 = cyc;
        pushCpu(c0 + 4, 8'hFF);
        @(negedge clk);
        checkOutput("simul vid_gnt +0", 32'(vid_gnt), 32'd1);
        @(negedge clk);
        checkOutput("simul vid_gnt +1", 32'(vid_gnt), 32'd1);
        @(posedge clk); #1;
        vidEnable = 1'b0;
        @(negedge clk);
        checkOutput("simul vid_req dropped", 32'(vid_req), 32'd0);
        @(negedge clk);
        checkOutput("simul cpu issue addr", 32'(ram_addr), 32'h3FF);
        checkOutput("simul cpu issue we", 32'(ram_we), 32'd0);
        @(negedge clk);
        checkOutput("simul cpu_ack", 32'(cpu_ack), 32'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0;
        // Counter must have cleared: a new request again waits the full 4 cycles.
        vidEnable = 1'b1;
        idleCycles(4);
        applyStimulus(1'b0, 10'h155, 8'h00, 4, 8'hA5);
        vidEnable = 1'b0;
        idleCycles(4);

        // Held request: two complete write ops, never a double grant.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'h2F0; cpu_din = 8'h5A;
        c0 = cyc;
        pushCpu(c0 + 2, 8'hA5);
        pushCpu(c0 + 5, 8'hA5);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput($sformatf("held ram_we +%0d", i), 32'(ram_we), 32'(i == 1 || i == 4));
            checkOutput($sformatf("held cpu_ack +%0d", i), 32'(cpu_ack), 32'(i == 2 || i == 5));
        end
        @(posedge clk); #1;
        cpu_req = 1'b0;
        idleCycles(3);

        // Reset one cycle after a CPU read grant: the read never completes.
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'h2F0;
        pushCpu(cyc + 2, 8'h5A);
        @(posedge clk); #1;
        reset = 1'b1;
        cpu_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        checkOutput("midreset ram_addr", 32'(ram_addr), 32'd0);
        checkOutput("midreset ram_we", 32'(ram_we), 32'd0);
        checkOutput("midreset cpu_ack", 32'(cpu_ack), 32'd0);
        checkOutput("midreset cpu_dout", 32'(cpu_dout), 32'd0);
        checkOutput("midreset vid_valid", 32'(vid_valid), 32'd0);
        checkOutput("midreset vid_data", 32'(vid_data), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midreset no ack", 32'(cpu_ack), 32'd0);
        end
        applyStimulus(1'b0, 10'h2F0, 8'h00, 0, 8'h5A);
        idleCycles(4);

        checkOutput("scoreboard drained", 32'(vidQ.size() + cpuQ.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
